// File: rtl/piso_stream.sv
// -----------------------------------------------------------------------------
// piso_stream
//   Parallel-in serial-out word serializer. A whole N-bit block is captured in
//   one handshake and emitted as WORDS = N/M words of M bits over a valid/ready
//   stream, least-significant word first. This is the exact inverse of the
//   SIPO word collector, so serialize -> collect round-trips bit-identically.
//
// Ports
//   clk         rising-edge clock
//   rst_n       synchronous active-low reset
//   load_valid  load_data holds a block to serialize
//   load_ready  block accepted on load_valid && load_ready
//   load_data   parallel block; word k is load_data[M*k +: M]
//   out_valid   out_data holds a valid word
//   out_ready   downstream accepts the word this cycle
//   out_data    current word
//   out_last    current word is the final word of the block
//   busy        a block is held (same as out_valid)
// -----------------------------------------------------------------------------
module piso_stream #(
    parameter int N = 1344,
    parameter int M = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_valid,
    output logic         load_ready,
    input  logic [N-1:0] load_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [M-1:0] out_data,
    output logic         out_last,
    output logic         busy
);

    localparam int WORDS = N / M;
    localparam int CW    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(WORDS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t         r_state;
    logic [N-1:0]   r_shift;
    logic [CW-1:0]  r_cnt;

    state_t         w_state_nxt;
    logic [N-1:0]   w_shift_nxt;
    logic [CW-1:0]  w_cnt_nxt;
    logic           w_is_last;
    logic           w_xfer;
    logic           w_load;

    // Output word is always the bottom of the shift register; after the last
    // word has been shifted out the register is all zeros, so IDLE drives 0.
    assign out_data  = r_shift[M-1:0];
    assign out_valid = (r_state == SEND);
    assign busy      = out_valid;
    assign w_is_last = (r_state == SEND) && (r_cnt == LAST_IDX);
    assign out_last  = w_is_last;

    // A new block may be accepted while the final word of the current one is
    // leaving, which keeps back-to-back blocks bubble-free.
    assign load_ready = (r_state == IDLE) || (out_ready && w_is_last);

    assign w_xfer = out_valid && out_ready;
    assign w_load = load_valid && load_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_cnt_nxt   = r_cnt;

        if (w_load) begin
            w_state_nxt = SEND;
            w_shift_nxt = load_data;
            w_cnt_nxt   = '0;
        end else if (w_xfer) begin
            w_shift_nxt = {{M{1'b0}}, r_shift[N-1:M]};
            if (w_is_last) begin
                // Counter parks at the last index until the next load.
                w_state_nxt = IDLE;
            end else begin
                w_cnt_nxt = r_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_piso_stream.sv
module tb_piso_stream;

    localparam int N     = 1344;
    localparam int M     = 64;
    localparam int WORDS = N / M;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         load_valid;
    logic         load_ready;
    logic [N-1:0] load_data;
    logic         out_valid;
    logic         out_ready;
    logic [M-1:0] out_data;
    logic         out_last;
    logic         busy;

    always #5 clk = ~clk;

    piso_stream #(.N(N), .M(M)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .busy       (busy)
    );

    typedef struct {
        logic [M-1:0] data;
        logic         last;
    } exp_t;

    exp_t         q[$];
    int           n_checks = 0;
    int           n_fail   = 0;
    int           n_xfer   = 0;
    logic         acc      = 1'b0;
    logic         prev_stall = 1'b0;
    logic [M-1:0] prev_data;
    logic         prev_last;
    logic [N-1:0] col = '0;

    task automatic check(input string tag, input logic [M-1:0] obs, input logic [M-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] make_block(input logic [M-1:0] base);
        logic [N-1:0] b;
        for (int k = 0; k < WORDS; k++) b[k*M +: M] = base + M'(k);
        return b;
    endfunction

    // Evaluate the handshakes that will happen at the coming rising edge.
    task automatic monitor();
        exp_t e;
        acc = 1'b0;
        if (!rst_n) begin
            q.delete();
            prev_stall = 1'b0;
            return;
        end
        if (prev_stall) begin
            check("stall_valid", M'(out_valid), M'(1));
            check("stall_data", out_data, prev_data);
            check("stall_last", M'(out_last), M'(prev_last));
        end
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                check("extra_word", out_data, ~out_data);
            end else begin
                e = q.pop_front();
                check("data", out_data, e.data);
                check("last", M'(out_last), M'(e.last));
            end
            col = {out_data, col[N-1:M]};
            n_xfer++;
        end
        if (load_valid && load_ready) begin
            for (int k = 0; k < WORDS; k++) begin
                e.data = load_data[k*M +: M];
                e.last = (k == WORDS - 1);
                q.push_back(e);
            end
            acc = 1'b1;
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_last  = out_last;
    endtask

    task automatic cycle();
        #1;
        monitor();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic load_block(input logic [N-1:0] b);
        int c;
        c = 0;
        load_data  = b;
        load_valid = 1'b1;
        do begin
            cycle();
            c++;
        end while (!acc && c < 10);
        check("load_accept", M'(acc), M'(1));
        load_valid = 1'b0;
    endtask

    task automatic drain(input int maxc);
        int c;
        c = 0;
        while (q.size() > 0 && c < maxc) begin
            cycle();
            c++;
        end
        check("drain_timeout", M'(q.size()), M'(0));
    endtask

    task automatic run_until_xfer(input int k);
        int c;
        c = 0;
        while (n_xfer < k && c < 100) begin
            cycle();
            c++;
        end
        check("xfer_timeout", M'(n_xfer), M'(k));
    endtask

    initial begin
        logic [N-1:0] blk;
        int           cyc;
        int           p;

        rst_n      = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        out_ready  = 1'b0;
        @(negedge clk);
        cycle();
        cycle();

        // Reset state
        check("rst_out_valid", M'(out_valid), M'(0));
        check("rst_load_ready", M'(load_ready), M'(1));
        check("rst_out_data", out_data, M'(0));
        check("rst_out_last", M'(out_last), M'(0));
        check("rst_busy", M'(busy), M'(0));
        rst_n = 1'b1;

        // Single block, out_ready held high
        out_ready = 1'b1;
        n_xfer = 0;
        load_block(make_block(64'h1));
        drain(100);
        check("t1_xfers", M'(n_xfer), M'(WORDS));
        check("t1_idle_valid", M'(out_valid), M'(0));
        check("t1_idle_ready", M'(load_ready), M'(1));
        check("t1_idle_data", out_data, M'(0));

        // Backpressure 1,0,0,1 pattern
        n_xfer = 0;
        load_block(make_block(64'h1));
        p = 0;
        while (q.size() > 0 && p < 300) begin
            out_ready = (p % 4 == 0) || (p % 4 == 3);
            cycle();
            p++;
        end
        check("t2_drain", M'(q.size()), M'(0));
        check("t2_xfers", M'(n_xfer), M'(WORDS));
        out_ready = 1'b1;
        cycle();

        // Back-to-back blocks with load_valid held
        n_xfer = 0;
        load_block(make_block(64'hA000));
        load_data  = make_block(64'hB000);
        load_valid = 1'b1;
        cyc = 0;
        while (q.size() > 0 && cyc < 100) begin
            cycle();
            cyc++;
            if (acc) begin
                check("t3_b_load_cycle", M'(cyc), M'(WORDS));
                load_valid = 1'b0;
            end
        end
        load_valid = 1'b0;
        check("t3_cycles", M'(cyc), M'(2 * WORDS));
        check("t3_xfers", M'(n_xfer), M'(2 * WORDS));
        cycle();

        // Load attempt while busy is ignored
        n_xfer = 0;
        load_block(make_block(64'h3000));
        run_until_xfer(5);
        out_ready  = 1'b0;
        load_valid = 1'b1;
        load_data  = make_block(64'h7000);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t4_load_ready", M'(load_ready), M'(0));
            check("t4_word5", out_data, 64'h3005);
            cycle();
        end
        load_valid = 1'b0;
        out_ready  = 1'b1;
        drain(100);
        check("t4_xfers", M'(n_xfer), M'(WORDS));
        check("t4_idle_valid", M'(out_valid), M'(0));

        // Reset mid-block
        n_xfer = 0;
        load_block(make_block(64'h5000));
        run_until_xfer(11);
        rst_n = 1'b0;
        cycle();
        check("t5_out_valid", M'(out_valid), M'(0));
        check("t5_out_data", out_data, M'(0));
        check("t5_out_last", M'(out_last), M'(0));
        check("t5_load_ready", M'(load_ready), M'(1));
        check("t5_busy", M'(busy), M'(0));
        rst_n = 1'b1;
        n_xfer = 0;
        load_block(make_block(64'h6000));
        #1;
        check("t5_restart_word0", out_data, 64'h6000);
        drain(100);
        check("t5_xfers", M'(n_xfer), M'(WORDS));

        // Round trip through a 64-bit collector model, random backpressure
        for (int i = 0; i < N / 32; i++) blk[i*32 +: 32] = $urandom;
        col    = '0;
        n_xfer = 0;
        load_block(blk);
        cyc = 0;
        while (n_xfer < WORDS && cyc < 300) begin
            out_ready = 1'($urandom_range(0, 1));
            cycle();
            cyc++;
        end
        check("t6_xfers", M'(n_xfer), M'(WORDS));
        for (int k = 0; k < WORDS; k++)
            check($sformatf("t6_roundtrip_w%0d", k), col[k*M +: M], blk[k*M +: M]);
        check("t6_queue", M'(q.size()), M'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
